// File: rtl/instr_dispatcher.sv
// Instruction dispatcher: buffers host instruction words in a FIFO and feeds
// them one at a time to a cpu through its load/start/wait handshake.
module instr_dispatcher #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    output logic        full,
    output logic        empty,
    output logic [15:0] in,
    output logic        load,
    output logic        s,
    input  logic        w,
    input  logic [15:0] out,
    input  logic        N,
    input  logic        V,
    input  logic        Z,
    output logic        res_valid,
    output logic [15:0] res_data,
    output logic        res_N,
    output logic        res_V,
    output logic        res_Z,
    output logic [7:0]  retired,
    output logic        overflow,
    output logic        error
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        HALT
    } state_t;

    state_t        state_reg;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [CW-1:0] wait_cnt_reg;

    logic push;
    logic fire;
    logic retire;
    logic waiting;
    logic timeout_hit;

    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);

    // A push is judged against the occupancy at the start of the cycle, so a
    // same-cycle pop never rescues a push into a full queue.
    assign push        = wr_en && !full;
    assign fire        = (state_reg == IDLE) && !empty && w;
    assign retire      = (state_reg == WAIT_DONE) && w;
    assign waiting     = ((state_reg == WAIT_BUSY) && w) || ((state_reg == WAIT_DONE) && !w);
    assign timeout_hit = waiting && (wait_cnt_reg == CW'(TIMEOUT - 1));

    // Storage plus registered head read; the read register doubles as the
    // cpu instruction bus and is zeroed whenever no dispatch is in flight.
    always_ff @(posedge clk) begin
        if (push && !reset)
            mem[wr_ptr_reg] <= wr_data;
        if (reset || retire || timeout_hit)
            in <= '0;
        else if (fire)
            in <= mem[rd_ptr_reg];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (retire)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push, retire})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
            if (wr_en && full)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            load         <= 1'b0;
            s            <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_N        <= 1'b0;
            res_V        <= 1'b0;
            res_Z        <= 1'b0;
            retired      <= '0;
            error        <= 1'b0;
        end else begin
            load      <= 1'b0;
            s         <= 1'b0;
            res_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (fire) begin
                        state_reg <= LOAD;
                        load      <= 1'b1;
                    end
                end
                LOAD: begin
                    state_reg <= START;
                    s         <= 1'b1;
                end
                START: begin
                    state_reg    <= WAIT_BUSY;
                    wait_cnt_reg <= '0;
                end
                WAIT_BUSY: begin
                    if (!w) begin
                        state_reg    <= WAIT_DONE;
                        wait_cnt_reg <= '0;
                    end else if (timeout_hit) begin
                        state_reg <= HALT;
                        error     <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (retire) begin
                        state_reg <= IDLE;
                        res_valid <= 1'b1;
                        res_data  <= out;
                        res_N     <= N;
                        res_V     <= V;
                        res_Z     <= Z;
                        retired   <= retired + 8'd1;
                    end else if (timeout_hit) begin
                        state_reg <= HALT;
                        error     <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CW'(1);
                    end
                end
                HALT: state_reg <= HALT;
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_dispatcher.sv
// Randomized bench for instr_dispatcher: a queue-based model of accepted words
// plus a behavioural cpu responder whose result is a fixed function of the word.
module tb_instr_dispatcher;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic        full, empty, load, s, res_valid, res_N, res_V, res_Z, overflow, error;
    logic [15:0] in, res_data;
    logic [7:0]  retired;
    logic        w = 1'b1;
    logic [15:0] out = '0;
    logic        N = 1'b0, V = 1'b0, Z = 1'b0;

    always #5 clk = ~clk;

    instr_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .in(in), .load(load), .s(s), .w(w),
        .out(out), .N(N), .V(V), .Z(Z), .res_valid(res_valid),
        .res_data(res_data), .res_N(res_N), .res_V(res_V), .res_Z(res_Z),
        .retired(retired), .overflow(overflow), .error(error)
    );

    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];
    logic        ovf_m = 1'b0;
    int          ret_m = 0;
    logic        prev_load = 1'b0;

    // cpu responder: 0 = normal, 1 = stuck busy (w=0), 2 = never goes busy (w=1)
    int          cpu_mode = 0;
    int          busy_lo = 2;
    int          busy_hi = 6;
    int          busy_cnt = 0;
    logic [15:0] cpu_ir = '0;

    function automatic logic [15:0] alu(input logic [15:0] x);
        return {x[7:0], x[15:8]} + 16'h1234;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            w = 1'b1;
            busy_cnt = 0;
        end else if (cpu_mode == 1) begin
            w = 1'b0;
        end else if (cpu_mode == 2) begin
            w = 1'b1;
        end else begin
            if (load) cpu_ir = in;
            if (s) begin
                w = 1'b0;
                busy_cnt = $urandom_range(busy_hi, busy_lo);
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    w = 1'b1;
                    out = alu(cpu_ir);
                    N = cpu_ir[15];
                    V = cpu_ir[0];
                    Z = (cpu_ir[7:0] == 8'h00);
                end
            end else begin
                w = 1'b1;
            end
        end
    end

    task automatic apply_reset();
        reset = 1'b1;
        wr_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        ovf_m = 1'b0;
        ret_m = 0;
        prev_load = 1'b0;
    endtask

    // One clock with optional push; the model follows the queue rules and the
    // per-cycle observations are compared against it.
    task automatic step(input logic do_push, input logic [15:0] data);
        logic acc;
        wr_en = do_push;
        wr_data = data;
        acc = do_push && (exp_q.size() < DEPTH);
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (do_push && !acc) ovf_m = 1'b1;
        if (res_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL res_valid_unexpected: res_data=%h with model queue empty", res_data);
            end else begin
                if (res_data !== alu(exp_q[0]) || res_N !== exp_q[0][15] ||
                    res_V !== exp_q[0][0] || res_Z !== (exp_q[0][7:0] == 8'h00)) begin
                    n_fail++;
                    $display("FAIL result: got %h NVZ=%b%b%b, expected %h NVZ=%b%b%b (word %h)",
                             res_data, res_N, res_V, res_Z, alu(exp_q[0]), exp_q[0][15],
                             exp_q[0][0], exp_q[0][7:0] == 8'h00, exp_q[0]);
                end
                void'(exp_q.pop_front());
                ret_m++;
            end
        end
        if (acc) exp_q.push_back(data);
        n_tests++;
        if (retired !== 8'(ret_m)) begin
            n_fail++;
            $display("FAIL retired: got %0d, expected %0d", retired, 8'(ret_m));
        end
        n_tests++;
        if (full !== (exp_q.size() == DEPTH) || empty !== (exp_q.size() == 0)) begin
            n_fail++;
            $display("FAIL full_empty: got full=%b empty=%b, expected occupancy %0d", full, empty, exp_q.size());
        end
        n_tests++;
        if (overflow !== ovf_m) begin
            n_fail++;
            $display("FAIL overflow: got %b, expected %b", overflow, ovf_m);
        end
        n_tests++;
        if ((load && s) || (s && !prev_load) || (load && prev_load)) begin
            n_fail++;
            $display("FAIL strobes: load=%b s=%b prev_load=%b, expected single load then single s", load, s, prev_load);
        end
        if (load) begin
            n_tests++;
            if (exp_q.size() == 0 || in !== exp_q[0]) begin
                n_fail++;
                $display("FAIL dispatch_word: in=%h, expected head %h (occupancy %0d)",
                         in, (exp_q.size() == 0) ? 16'h0000 : exp_q[0], exp_q.size());
            end
        end
        prev_load = load;
    endtask

    task automatic test_reset();
        cpu_mode = 0;
        reset = 1'b1;
        wr_en = 1'b1;
        wr_data = 16'hBEEF;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got empty=%b full=%b, expected empty=1 full=0", empty, full);
        end
        n_tests++;
        if (in !== 16'h0000 || load !== 1'b0 || s !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cpu_if: got in=%h load=%b s=%b, expected 0000 0 0", in, load, s);
        end
        n_tests++;
        if (res_valid !== 1'b0 || res_data !== 16'h0000 || {res_N, res_V, res_Z} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_result: got valid=%b data=%h NVZ=%b%b%b, expected all 0",
                     res_valid, res_data, res_N, res_V, res_Z);
        end
        n_tests++;
        if (retired !== 8'd0 || overflow !== 1'b0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: got retired=%0d overflow=%b error=%b, expected 0 0 0",
                     retired, overflow, error);
        end
        reset = 1'b0;
        wr_en = 1'b0;
        exp_q.delete();
        ovf_m = 1'b0;
        ret_m = 0;
        prev_load = 1'b0;
    endtask

    task automatic test_latency();
        int k;
        apply_reset();
        cpu_mode = 0;
        step(1'b1, 16'hD008);
        n_tests++;
        if (load !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: load=%b one cycle after push, expected 0", load);
        end
        step(1'b0, 16'h0000);
        n_tests++;
        if (load !== 1'b1 || in !== 16'hD008) begin
            n_fail++;
            $display("FAIL latency: load=%b in=%h two cycles after push, expected 1 D008", load, in);
        end
        step(1'b1, 16'hD105);
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            step(1'b0, 16'h0000);
            k++;
        end
        n_tests++;
        if (exp_q.size() != 0 || retired !== 8'd2) begin
            n_fail++;
            $display("FAIL latency_drain: retired=%0d pending=%0d, expected 2 0", retired, exp_q.size());
        end
    endtask

    task automatic test_random_traffic();
        int k;
        apply_reset();
        cpu_mode = 0;
        for (int i = 0; i < 400; i++)
            step($urandom_range(99, 0) < 35, 16'($urandom));
        k = 0;
        while (exp_q.size() != 0 && k < 600) begin
            step(1'b0, 16'h0000);
            k++;
        end
        n_tests++;
        if (exp_q.size() != 0 || empty !== 1'b1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL random_drain: pending=%0d empty=%b error=%b, expected 0 1 0", exp_q.size(), empty, error);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        apply_reset();
        cpu_mode = 0;
        busy_lo = 2;
        busy_hi = 2;
        for (int i = 0; i < 80; i++)
            step(1'b1, 16'($urandom));
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            step(1'b0, 16'h0000);
            k++;
        end
        busy_hi = 6;
        n_tests++;
        if (exp_q.size() != 0 || retired !== 8'(ret_m) || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_drain: pending=%0d retired=%0d overflow=%b, expected 0 %0d 1",
                     exp_q.size(), retired, overflow, 8'(ret_m));
        end
    endtask

    task automatic test_overflow();
        int k;
        apply_reset();
        cpu_mode = 1;
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 16'h3000 + 16'(i * 17));
        n_tests++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fill: got full=%b overflow=%b after %0d pushes, expected 1 0", full, overflow, DEPTH);
        end
        step(1'b1, 16'hFFFF);
        n_tests++;
        if (overflow !== 1'b1 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_push: got overflow=%b full=%b, expected 1 1", overflow, full);
        end
        cpu_mode = 0;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            step(1'b0, 16'h0000);
            k++;
        end
        n_tests++;
        if (retired !== 8'(DEPTH) || empty !== 1'b1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_drain: retired=%0d empty=%b overflow=%b, expected %0d 1 1",
                     retired, empty, overflow, DEPTH);
        end
    endtask

    task automatic test_timeout();
        int k;
        logic seen_valid;
        apply_reset();
        cpu_mode = 2;
        step(1'b1, 16'hA148);
        k = 0;
        while (s !== 1'b1 && k < 10) begin
            step(1'b0, 16'h0000);
            k++;
        end
        k = 0;
        seen_valid = 1'b0;
        while (error !== 1'b1 && k < TIMEOUT + 10) begin
            step(1'b0, 16'h0000);
            if (res_valid) seen_valid = 1'b1;
            k++;
        end
        n_tests++;
        if (k != TIMEOUT + 1 || error !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_cycles: error=%b after %0d cycles, expected error at %0d", error, k, TIMEOUT + 1);
        end
        n_tests++;
        if (seen_valid || empty !== 1'b0 || in !== 16'h0000) begin
            n_fail++;
            $display("FAIL halt_state: res_valid_seen=%b empty=%b in=%h, expected 0 0 0000", seen_valid, empty, in);
        end
        step(1'b1, 16'h1111);
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 16'h0000);
            if (load || s) seen_valid = 1'b1;
        end
        n_tests++;
        if (seen_valid || error !== 1'b1 || exp_q.size() != 2) begin
            n_fail++;
            $display("FAIL halt_dispatch: strobe_seen=%b error=%b occupancy=%0d, expected 0 1 2",
                     seen_valid, error, exp_q.size());
        end
        apply_reset();
        n_tests++;
        if (error !== 1'b0 || empty !== 1'b1 || in !== 16'h0000 || retired !== 8'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_reset: error=%b empty=%b in=%h retired=%0d overflow=%b, expected 0 1 0000 0 0",
                     error, empty, in, retired, overflow);
        end
    endtask

    task automatic test_reset_midflight();
        int k;
        apply_reset();
        cpu_mode = 0;
        busy_lo = 15;
        busy_hi = 15;
        step(1'b1, 16'hA900);
        k = 0;
        while (s !== 1'b1 && k < 10) begin
            step(1'b0, 16'h0000);
            k++;
        end
        step(1'b0, 16'h0000);
        step(1'b0, 16'h0000);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        ovf_m = 1'b0;
        ret_m = 0;
        prev_load = 1'b0;
        n_tests++;
        if (load !== 1'b0 || s !== 1'b0 || retired !== 8'd0 || empty !== 1'b1 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight_reset: load=%b s=%b retired=%0d empty=%b res_valid=%b, expected 0 0 0 1 0",
                     load, s, retired, empty, res_valid);
        end
        busy_lo = 2;
        busy_hi = 6;
        for (int i = 0; i < 30; i++)
            step(1'b0, 16'h0000);
        n_tests++;
        if (retired !== 8'd0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight_after: retired=%0d error=%b, expected 0 0", retired, error);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_random_traffic();
        test_back_to_back();
        test_overflow();
        test_timeout();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
